// File: rtl/memory_match_judge.sv
// Turn judge for the memory game: pairs two picks, scores matches, times mismatches and requests hides.
// Optional build macro MATCH_KEEP_TURN_EN: a player who scores a match keeps the turn.
module memory_match_judge #(
    parameter int PAIRS       = 8,
    parameter int SHOW_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [3:0] card_val,
    input  logic [1:0] card_x,
    input  logic [1:0] card_y,
    input  logic       timeout,
    output logic       turn,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       match_pulse,
    output logic       mismatch_pulse,
    output logic       hide_req,
    output logic [1:0] hide_x1,
    output logic [1:0] hide_y1,
    output logic [1:0] hide_x2,
    output logic [1:0] hide_y2,
    output logic       hide_two,
    output logic       game_over,
    output logic       busy
);

    localparam int CW = (SHOW_CYCLES < 1) ? 1 : $clog2(SHOW_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SHOW_CYCLES - 1);
    localparam logic [3:0]    PAIRS_W  = 4'(PAIRS);

    typedef enum logic [2:0] {
        ST_FIRST  = 3'd0,
        ST_SECOND = 3'd1,
        ST_CMP    = 3'd2,
        ST_SHOW   = 3'd3,
        ST_HIDE   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        sat_inc = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t         state_q, state_d;
    logic [2:0]     p1_id_q, p1_id_d, p2_id_q, p2_id_d;
    logic [1:0]     p1_x_q, p1_x_d, p1_y_q, p1_y_d;
    logic [1:0]     p2_x_q, p2_x_d, p2_y_q, p2_y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           turn_q, turn_d;
    logic [3:0]     score1_q, score1_d, score2_q, score2_d;
    logic [3:0]     pairs_q, pairs_d;
    logic           match_q, match_d, mismatch_q, mismatch_d;
    logic           hide_req_q, hide_req_d, hide_two_q, hide_two_d;
    logic [1:0]     hx1_q, hx1_d, hy1_q, hy1_d, hx2_q, hx2_d, hy2_q, hy2_d;
    logic           game_over_q, game_over_d;
    logic           busy_q, busy_d;
    logic [3:0]     pairs_inc_s;
    logic           same_pos_s;
    logic           unused_face_s;

    // The face-up flag carries no information for judging a pair.
    assign unused_face_s = card_val[3];
    assign pairs_inc_s   = pairs_q + 4'd1;
    assign same_pos_s    = (card_x == p1_x_q) && (card_y == p1_y_q);

    // State, pick and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_FIRST;
            p1_id_q     <= 3'd0;
            p1_x_q      <= 2'd0;
            p1_y_q      <= 2'd0;
            p2_id_q     <= 3'd0;
            p2_x_q      <= 2'd0;
            p2_y_q      <= 2'd0;
            cnt_q       <= '0;
            turn_q      <= 1'b0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            pairs_q     <= 4'd0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            hide_req_q  <= 1'b0;
            hide_two_q  <= 1'b0;
            hx1_q       <= 2'd0;
            hy1_q       <= 2'd0;
            hx2_q       <= 2'd0;
            hy2_q       <= 2'd0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_id_q     <= p1_id_d;
            p1_x_q      <= p1_x_d;
            p1_y_q      <= p1_y_d;
            p2_id_q     <= p2_id_d;
            p2_x_q      <= p2_x_d;
            p2_y_q      <= p2_y_d;
            cnt_q       <= cnt_d;
            turn_q      <= turn_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            pairs_q     <= pairs_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            hide_req_q  <= hide_req_d;
            hide_two_q  <= hide_two_d;
            hx1_q       <= hx1_d;
            hy1_q       <= hy1_d;
            hx2_q       <= hx2_d;
            hy2_q       <= hy2_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output decode for the turn sequence.
    always_comb begin
        state_d     = state_q;
        p1_id_d     = p1_id_q;
        p1_x_d      = p1_x_q;
        p1_y_d      = p1_y_q;
        p2_id_d     = p2_id_q;
        p2_x_d      = p2_x_q;
        p2_y_d      = p2_y_q;
        cnt_d       = cnt_q;
        turn_d      = turn_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        pairs_d     = pairs_q;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        hide_req_d  = 1'b0;
        hide_two_d  = hide_two_q;
        hx1_d       = hx1_q;
        hy1_d       = hy1_q;
        hx2_d       = hx2_q;
        hy2_d       = hy2_q;
        game_over_d = game_over_q;

        case (state_q)
            ST_FIRST: begin
                if (sel_valid) begin
                    p1_id_d = card_val[2:0];
                    p1_x_d  = card_x;
                    p1_y_d  = card_y;
                    state_d = ST_SECOND;
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_SECOND: begin
                // A re-click on the first card is not a second pick.
                if (sel_valid) begin
                    if (same_pos_s) begin
                        state_d = ST_SECOND;
                    end else begin
                        p2_id_d = card_val[2:0];
                        p2_x_d  = card_x;
                        p2_y_d  = card_y;
                        state_d = ST_CMP;
                    end
                end else if (timeout) begin
                    hide_req_d = 1'b1;
                    hide_two_d = 1'b0;
                    hx1_d      = p1_x_q;
                    hy1_d      = p1_y_q;
                    turn_d     = ~turn_q;
                    state_d    = ST_FIRST;
                end else begin
                    state_d = ST_SECOND;
                end
            end
            ST_CMP: begin
                if (p1_id_q == p2_id_q) begin
                    match_d = 1'b1;
                    pairs_d = pairs_inc_s;
                    if (turn_q) begin
                        score2_d = sat_inc(score2_q);
                    end else begin
                        score1_d = sat_inc(score1_q);
                    end
                    if (pairs_inc_s == PAIRS_W) begin
                        game_over_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
`ifdef MATCH_KEEP_TURN_EN
                        turn_d = turn_q;
`else
                        turn_d = ~turn_q;
`endif
                        state_d = ST_FIRST;
                    end
                end else begin
                    mismatch_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIDE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HIDE: begin
                hide_req_d = 1'b1;
                hide_two_d = 1'b1;
                hx1_d      = p1_x_q;
                hy1_d      = p1_y_q;
                hx2_d      = p2_x_q;
                hy2_d      = p2_y_q;
                turn_d     = ~turn_q;
                state_d    = ST_FIRST;
            end
            ST_DONE: begin
                game_over_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase

        busy_d = (state_d == ST_CMP) || (state_d == ST_SHOW) || (state_d == ST_HIDE);
    end

    assign turn           = turn_q;
    assign score_p1       = score1_q;
    assign score_p2       = score2_q;
    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;
    assign hide_req       = hide_req_q;
    assign hide_two       = hide_two_q;
    assign hide_x1        = hx1_q;
    assign hide_y1        = hy1_q;
    assign hide_x2        = hx2_q;
    assign hide_y2        = hy2_q;
    assign game_over      = game_over_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_memory_match_judge.sv
// Self-checking bench for memory_match_judge: vector table, hand-written corner cases, randomized turns.
module tb_memory_match_judge;

    localparam int PAIRS = 8;
    localparam int SHOW  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel_valid = 1'b0;
    logic [3:0] card_val = 4'd0;
    logic [1:0] card_x = 2'd0;
    logic [1:0] card_y = 2'd0;
    logic       timeout = 1'b0;
    logic       turn, match_pulse, mismatch_pulse, hide_req, hide_two, game_over, busy;
    logic [3:0] score_p1, score_p2;
    logic [1:0] hide_x1, hide_y1, hide_x2, hide_y2;

    int total = 0;
    int bad   = 0;

    // Reference model: game-level bookkeeping only.
    int ex_score[2];
    int ex_turn;
    int ex_pairs;
    bit ex_over;

    typedef struct {
        logic [1:0] x1, y1;
        logic [3:0] v1;
        logic [1:0] x2, y2;
        logic [3:0] v2;
        bit         exp_m;
    } vec_t;
    vec_t tbl[6];

    memory_match_judge #(.PAIRS(PAIRS), .SHOW_CYCLES(SHOW)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .card_val(card_val),
        .card_x(card_x), .card_y(card_y), .timeout(timeout), .turn(turn),
        .score_p1(score_p1), .score_p2(score_p2), .match_pulse(match_pulse),
        .mismatch_pulse(mismatch_pulse), .hide_req(hide_req), .hide_x1(hide_x1),
        .hide_y1(hide_y1), .hide_x2(hide_x2), .hide_y2(hide_y2), .hide_two(hide_two),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit keep_turn();
`ifdef MATCH_KEEP_TURN_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic [1:0] x, input logic [1:0] y, input logic [3:0] v);
        sel_valid = 1'b1;
        card_x    = x;
        card_y    = y;
        card_val  = v;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic model_match();
        ex_score[ex_turn] = (ex_score[ex_turn] < 15) ? ex_score[ex_turn] + 1 : 15;
        ex_pairs++;
        if (ex_pairs == PAIRS) ex_over = 1'b1;
        else if (!keep_turn()) ex_turn ^= 1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_turn"}, turn, ex_turn);
        chk({tag, "_score_p1"}, score_p1, ex_score[0]);
        chk({tag, "_score_p2"}, score_p2, ex_score[1]);
        chk({tag, "_game_over"}, game_over, ex_over);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sel_valid = 1'b0;
        timeout = 1'b0;
        tick();
        rst = 1'b1;
        ex_score[0] = 0;
        ex_score[1] = 0;
        ex_turn = 0;
        ex_pairs = 0;
        ex_over = 1'b0;
        chk("rst_pulses", {match_pulse, mismatch_pulse, hide_req, hide_two}, 0);
        chk("rst_hide_xy", {hide_x1, hide_y1, hide_x2, hide_y2}, 0);
        chk("rst_busy", busy, 0);
        check_state("rst");
    endtask

    // Called on the mismatch_pulse cycle; follows the SHOW period up to the hide request.
    task automatic wait_hide(input logic [1:0] x1, input logic [1:0] y1,
                             input logic [1:0] x2, input logic [1:0] y2);
        int k;
        bit busy_ok;
        k = 0;
        busy_ok = 1'b1;
        while (hide_req !== 1'b1 && k < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            k++;
        end
        chk("hide_latency", k, SHOW + 1);
        chk("busy_in_show", busy_ok, 1);
        chk("hide_two", hide_two, 1);
        chk("hide_xy", {hide_x1, hide_y1, hide_x2, hide_y2}, {x1, y1, x2, y2});
        chk("busy_after_hide", busy, 0);
        ex_turn ^= 1;
        check_state("hide");
    endtask

    task automatic play_turn(input logic [1:0] x1, input logic [1:0] y1, input logic [3:0] v1,
                             input logic [1:0] x2, input logic [1:0] y2, input logic [3:0] v2,
                             input bit exp_m);
        pick(x1, y1, v1);
        chk("busy_pick1", busy, 0);
        pick(x2, y2, v2);
        chk("busy_cmp", busy, 1);
        tick();
        chk("match_pulse", match_pulse, exp_m);
        chk("mismatch_pulse", mismatch_pulse, !exp_m);
        chk("hide_req_at_cmp", hide_req, 0);
        if (exp_m) begin
            model_match();
            check_state("match");
        end else begin
            check_state("mismatch");
            wait_hide(x1, y1, x2, y2);
        end
    endtask

    task automatic tmo_turn(input logic [1:0] x, input logic [1:0] y, input logic [3:0] v);
        pick(x, y, v);
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        chk("tmo_hide_req", hide_req, 1);
        chk("tmo_hide_two", hide_two, 0);
        chk("tmo_hide_xy1", {hide_x1, hide_y1}, {x, y});
        chk("tmo_busy", busy, 0);
        ex_turn ^= 1;
        check_state("tmo");
        tick();
        chk("tmo_pulse_len", hide_req, 0);
    endtask

    initial begin
        tbl[0] = '{2'd0, 2'd0, 4'b0000, 2'd3, 2'd2, 4'b1000, 1'b1};
        tbl[1] = '{2'd1, 2'd0, 4'b0011, 2'd2, 2'd1, 4'b0110, 1'b0};
        tbl[2] = '{2'd2, 2'd3, 4'b1101, 2'd0, 2'd1, 4'b0101, 1'b1};
        tbl[3] = '{2'd3, 2'd3, 4'b0111, 2'd3, 2'd0, 4'b0110, 1'b0};
        tbl[4] = '{2'd1, 2'd1, 4'b1010, 2'd2, 2'd2, 4'b0010, 1'b1};
        tbl[5] = '{2'd0, 2'd3, 4'b1100, 2'd1, 2'd2, 4'b0011, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            play_turn(tbl[i].x1, tbl[i].y1, tbl[i].v1, tbl[i].x2, tbl[i].y2, tbl[i].v2, tbl[i].exp_m);
        end

        // Re-clicking the first card leaves the judge waiting for a real second pick.
        pick(2'd2, 2'd0, 4'd1);
        pick(2'd2, 2'd0, 4'd1);
        chk("same_pos_busy", busy, 0);
        tick();
        chk("same_pos_pulses", {match_pulse, mismatch_pulse}, 0);
        pick(2'd3, 2'd1, 4'd4);
        chk("same_pos_then_cmp", busy, 1);
        tick();
        chk("same_pos_mismatch", mismatch_pulse, 1);
        wait_hide(2'd2, 2'd0, 2'd3, 2'd1);

        // Timeout in FIRST is ignored; timeout in SECOND hides the lone card.
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        chk("tmo_first_ignored", {hide_req, busy}, 0);
        tmo_turn(2'd0, 2'd2, 4'd5);

        // Selection beats timeout in the same cycle.
        pick(2'd1, 2'd3, 4'd5);
        sel_valid = 1'b1; card_x = 2'd2; card_y = 2'd3; card_val = 4'd13; timeout = 1'b1;
        tick();
        sel_valid = 1'b0; timeout = 1'b0;
        chk("sel_wins_busy", busy, 1);
        chk("sel_wins_no_hide", hide_req, 0);
        tick();
        chk("sel_wins_match", match_pulse, 1);
        model_match();
        check_state("sel_wins");

        // Full game of matches up to game over, then inputs are ignored.
        do_reset();
        for (int i = 0; i < PAIRS; i++) begin
            play_turn(2'(i), 2'd0, 4'(i), 2'(i), 2'd1, 4'(i + 8), 1'b1);
        end
        chk("done_game_over", game_over, 1);
        chk("done_score_sum", 32'(score_p1) + 32'(score_p2), PAIRS);
        pick(2'd0, 2'd0, 4'd0);
        pick(2'd1, 2'd0, 4'd0);
        tick();
        tick();
        chk("done_no_pulses", {match_pulse, mismatch_pulse, hide_req, busy}, 0);
        check_state("done");

        // Reset during SHOW cancels the pending hide.
        do_reset();
        pick(2'd1, 2'd0, 4'd3);
        pick(2'd2, 2'd1, 4'd6);
        tick();
        chk("show_rst_mismatch", mismatch_pulse, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("show_rst_outputs", {turn, score_p1, score_p2, match_pulse, mismatch_pulse,
                                 hide_req, hide_two, game_over, busy}, 0);
        chk("show_rst_hide_xy", {hide_x1, hide_y1, hide_x2, hide_y2}, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (hide_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            end
            chk("show_rst_no_hide", seen, 0);
        end

        // Randomized turns against the reference model.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            logic [1:0] x1, y1, x2, y2;
            logic [3:0] v1, v2;
            int r;
            if (ex_over) do_reset();
            r  = $urandom_range(0, 3);
            x1 = 2'($urandom);
            y1 = 2'($urandom);
            do begin
                x2 = 2'($urandom);
                y2 = 2'($urandom);
            end while (x2 == x1 && y2 == y1);
            v1 = 4'($urandom);
            v2 = 4'($urandom);
            if (r == 1) v2[2:0] = v1[2:0];
            if ($urandom_range(0, 3) == 0) begin
                timeout = 1'b1;
                tick();
                timeout = 1'b0;
                chk("rnd_tmo_first", hide_req, 0);
            end
            if (r == 0) tmo_turn(x1, y1, v1);
            else play_turn(x1, y1, v1, x2, y2, v2, v1[2:0] == v2[2:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
